param_inc_pipe: RTL and testbench

Registered, handshaked stage that adds a compile-time increment parameter to a data word. It applies the same parameter width, truncation and signedness rules as the combinational increment modules in the parameter-handling systests, and is the sequential consumer-side neighbour of those modules. It holds results in a 2-entry output FIFO with valid/ready flow control, and reports an overflow flag and an accepted-transaction count.

---
 rtl/param_inc_pipe_if.sv | 23 ++
 rtl/param_inc_pipe.sv | 185 ++++++++++++++++++
 tb/tb_param_inc_pipe.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_inc_pipe_if.sv
// Handshake bundle for param_inc_pipe: input valid/ready/data and output
// valid/ready/data/overflow, with producer (master) and stage (slave) views.
interface param_inc_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/param_inc_pipe.sv
// Registered add-a-parameter stage with a 2-entry output FIFO, overflow flag
// and accepted-word counter. Define PARAM_INC_SAT_EN to saturate instead of wrap.
module param_inc_pipe #(
    parameter int WIDTH      = 4,
    parameter int INC        = 1,
    parameter int INC_WIDTH  = 3,
    parameter int INC_SIGNED = 1,
    parameter int IN_SIGNED  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    param_inc_pipe_if.slave    bus,
    output logic [15:0]        count
);

    localparam bit SIGNED_EXPR = (IN_SIGNED != 0) && (INC_SIGNED != 0);
    localparam int SUM_W       = ((WIDTH > INC_WIDTH) ? WIDTH : INC_WIDTH) + 1;

    localparam logic [INC_WIDTH-1:0] INC_T    = INC[INC_WIDTH-1:0];
    localparam logic                 INC_SIGN = SIGNED_EXPR && INC_T[INC_WIDTH-1];
    localparam logic [SUM_W-1:0]     INC_EXT  = {{(SUM_W-INC_WIDTH){INC_SIGN}}, INC_T};

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] POS_MAX  = ALL_ONES >> 1;
    localparam logic [WIDTH-1:0] NEG_MIN  = ~POS_MAX;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } occ_e;

    occ_e             state_r;
    occ_e             state_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH:0]   head_r;
    logic [WIDTH:0]   tail_r;
    logic [15:0]      count_r;

    logic             push_s;
    logic             pop_s;
    logic             load_head_s;
    logic             load_tail_s;
    logic             shift_s;
    logic [SUM_W-1:0] sum_s;
    logic [SUM_W-WIDTH:0] upper_s;
    logic             ovf_s;
    logic [WIDTH-1:0] res_s;

    function automatic logic [SUM_W-1:0] ext_data(input logic [WIDTH-1:0] d);
        logic sign;
        sign = SIGNED_EXPR && d[WIDTH-1];
        return {{(SUM_W-WIDTH){sign}}, d};
    endfunction

    assign push_s = bus.in_valid & in_ready_r;
    assign pop_s  = out_valid_r & bus.out_ready;

    // Sum at full width, overflow detection and optional saturation.
    always_comb begin
        sum_s   = ext_data(bus.in_data) + INC_EXT;
        upper_s = sum_s[SUM_W-1:WIDTH-1];
        if (SIGNED_EXPR) begin
            // Signed result fits only when all bits from the sign position up agree.
            ovf_s = !((&upper_s) || !(|upper_s));
        end else begin
            ovf_s = |sum_s[SUM_W-1:WIDTH];
        end
`ifdef PARAM_INC_SAT_EN
        if (!ovf_s) begin
            res_s = sum_s[WIDTH-1:0];
        end else if (!SIGNED_EXPR) begin
            res_s = ALL_ONES;
        end else if (sum_s[SUM_W-1]) begin
            res_s = NEG_MIN;
        end else begin
            res_s = POS_MAX;
        end
`else
        res_s = sum_s[WIDTH-1:0];
`endif
    end

    // Occupancy next-state and FIFO load controls; clr overrides everything.
    always_comb begin
        state_s     = state_r;
        load_head_s = 1'b0;
        load_tail_s = 1'b0;
        shift_s     = 1'b0;
        if (clr) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_s     = ST_ONE;
                        load_head_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_s     = ST_ONE;
                        load_head_s = 1'b1;
                    end else if (push_s) begin
                        state_s     = ST_FULL;
                        load_tail_s = 1'b1;
                    end else if (pop_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (pop_s) begin
                        state_s = ST_ONE;
                        shift_s = 1'b1;
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state plus registered ready/valid derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s != ST_FULL);
            out_valid_r <= (state_s != ST_EMPTY);
        end
    end

    // FIFO storage; the head drives the outputs and holds its value when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {(WIDTH+1){1'b0}};
            tail_r <= {(WIDTH+1){1'b0}};
        end else begin
            if (load_head_s) begin
                head_r <= {ovf_s, res_s};
            end else if (shift_s) begin
                head_r <= tail_r;
            end else begin
                head_r <= head_r;
            end
            if (load_tail_s) begin
                tail_r <= {ovf_s, res_s};
            end else begin
                tail_r <= tail_r;
            end
        end
    end

    // Accepted-word counter, wrapping modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'd0;
        end else if (clr) begin
            count_r <= 16'd0;
        end else if (push_s) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = head_r[WIDTH-1:0];
    assign bus.out_ovf   = head_r[WIDTH];
    assign count         = count_r;

endmodule

// File: tb/tb_param_inc_pipe.sv
// Bench for param_inc_pipe: three parameterisations driven by one stimulus
// stream, checked against an arithmetic reference model and a result queue.
module tb_param_inc_pipe;

    localparam int IW = 3;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic [15:0] cnt_u, cnt_m, cnt_s;

    param_inc_pipe_if #(.WIDTH(4)) ifu ();
    param_inc_pipe_if #(.WIDTH(4)) ifm ();
    param_inc_pipe_if #(.WIDTH(4)) ifs ();

    assign ifu.in_valid = in_valid;  assign ifu.in_data = in_data;  assign ifu.out_ready = out_ready;
    assign ifm.in_valid = in_valid;  assign ifm.in_data = in_data;  assign ifm.out_ready = out_ready;
    assign ifs.in_valid = in_valid;  assign ifs.in_data = in_data;  assign ifs.out_ready = out_ready;

    // idx 0: defaults; idx 1: INC=-1 with unsigned input; idx 2: INC=-1 fully signed
    param_inc_pipe #(.WIDTH(4), .INC(1), .INC_WIDTH(IW), .INC_SIGNED(1), .IN_SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifu), .count(cnt_u));
    param_inc_pipe #(.WIDTH(4), .INC(-1), .INC_WIDTH(IW), .INC_SIGNED(1), .IN_SIGNED(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifm), .count(cnt_m));
    param_inc_pipe #(.WIDTH(4), .INC(-1), .INC_WIDTH(IW), .INC_SIGNED(1), .IN_SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifs), .count(cnt_s));

    logic [3:0]  o_data [3];
    logic        o_ovf  [3];
    logic        o_vld  [3];
    logic        o_rdy  [3];
    logic [15:0] o_cnt  [3];

    assign o_data[0] = ifu.out_data;  assign o_ovf[0] = ifu.out_ovf;  assign o_vld[0] = ifu.out_valid;
    assign o_data[1] = ifm.out_data;  assign o_ovf[1] = ifm.out_ovf;  assign o_vld[1] = ifm.out_valid;
    assign o_data[2] = ifs.out_data;  assign o_ovf[2] = ifs.out_ovf;  assign o_vld[2] = ifs.out_valid;
    assign o_rdy[0]  = ifu.in_ready;  assign o_rdy[1]  = ifm.in_ready; assign o_rdy[2]  = ifs.in_ready;
    assign o_cnt[0]  = cnt_u;         assign o_cnt[1]  = cnt_m;        assign o_cnt[2]  = cnt_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model state, shared because all three instances see identical flow control.
    logic [14:0] q [$];
    logic [15:0] m_count;
    bit          m_live;

    function automatic logic [4:0] ref_res(input int idx, input logic [3:0] din);
        int     inc;
        bit     sgn;
        longint m, inc_t, dv, t;
        logic   ovf;
        logic [3:0] d;
        inc   = (idx == 0) ? 1 : -1;
        sgn   = (idx == 2);
        m     = longint'(1) << IW;
        inc_t = ((longint'(inc) % m) + m) % m;
        if (sgn) begin
            if (inc_t >= m / 2) inc_t = inc_t - m;
            dv  = (din >= 4'd8) ? longint'(din) - 16 : longint'(din);
            t   = dv + inc_t;
            ovf = (t > 7) || (t < -8);
`ifdef PARAM_INC_SAT_EN
            if (t > 7) t = 7;
            else if (t < -8) t = -8;
`endif
        end else begin
            t   = longint'(din) + inc_t;
            ovf = (t >= 16);
`ifdef PARAM_INC_SAT_EN
            if (ovf) t = 15;
`endif
        end
        d = t[3:0];
        return {ovf, d};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_count = 16'd0;
        m_live  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_ready"}, i, 16'(o_rdy[i]), 16'd0);
            chk({tag, "_valid"}, i, 16'(o_vld[i]), 16'd0);
            chk({tag, "_data"},  i, 16'(o_data[i]), 16'd0);
            chk({tag, "_ovf"},   i, 16'(o_ovf[i]), 16'd0);
            chk({tag, "_count"}, i, o_cnt[i], 16'd0);
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cycle();
        bit          m_ready, m_valid, acc, pop;
        logic [14:0] e;
        logic [4:0]  r;
        m_valid = (q.size() != 0);
        m_ready = m_live && (q.size() < 2);
        for (int i = 0; i < 3; i++) begin
            chk("in_ready",  i, 16'(o_rdy[i]), 16'(m_ready));
            chk("out_valid", i, 16'(o_vld[i]), 16'(m_valid));
            chk("count",     i, o_cnt[i], m_count);
            if (m_valid) begin
                e = q[0];
                r = e[5*i +: 5];
                chk("out_data", i, 16'(o_data[i]), 16'(r[3:0]));
                chk("out_ovf",  i, 16'(o_ovf[i]),  16'(r[4]));
            end
        end
        acc = in_valid && m_ready;
        pop = m_valid && out_ready;
        @(posedge clk);
        @(negedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (clr) begin
            q.delete();
            m_count = 16'd0;
            m_live  = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back({ref_res(2, in_data), ref_res(1, in_data), ref_res(0, in_data)});
                m_count = m_count + 16'd1;
            end
            m_live = 1'b1;
        end
    endtask

    task automatic chk_head(input string tag, input int idx, input logic [3:0] d, input logic ovf);
        chk({tag, "_data"}, idx, 16'(o_data[idx]), 16'(d));
        chk({tag, "_ovf"},  idx, 16'(o_ovf[idx]),  16'(ovf));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("reset");

        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("ready_after_reset", 0, 16'(o_rdy[0]), 16'd1);

        // Wrap/overflow at the top of the unsigned range
        out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        cycle();
        in_valid = 1'b0;
`ifdef PARAM_INC_SAT_EN
        chk_head("tp_f", 0, 4'hF, 1'b1);
        chk_head("tp_f", 1, 4'hF, 1'b1);
`else
        chk_head("tp_f", 0, 4'h0, 1'b1);
        chk_head("tp_f", 1, 4'h6, 1'b1);
`endif
        chk_head("tp_f", 2, 4'hE, 1'b0);
        chk("tp_f_count", 0, o_cnt[0], 16'd1);
        cycle();

        in_valid = 1'b1; in_data = 4'd2;
        cycle();
        in_valid = 1'b0;
        chk_head("tp_2", 0, 4'h3, 1'b0);
        chk_head("tp_2", 1, 4'h9, 1'b0);
        chk_head("tp_2", 2, 4'h1, 1'b0);
        cycle();

        // Signed negative overflow
        in_valid = 1'b1; in_data = 4'h8;
        cycle();
        in_valid = 1'b0;
        chk_head("tp_8", 0, 4'h9, 1'b0);
        chk_head("tp_8", 1, 4'hF, 1'b0);
`ifdef PARAM_INC_SAT_EN
        chk_head("tp_8", 2, 4'h8, 1'b1);
`else
        chk_head("tp_8", 2, 4'h7, 1'b1);
`endif
        cycle();

        // Backpressure: only two words fit
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 4'($urandom);
            cycle();
        end
        chk("bp_ready", 0, 16'(o_rdy[0]), 16'd0);
        chk("bp_count", 0, o_cnt[0], 16'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        // Clear while full, with a push attempt in the same cycle
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("clr_valid", i, 16'(o_vld[i]), 16'd0);
            chk("clr_count", i, o_cnt[i], 16'd0);
            chk("clr_ready", i, 16'(o_rdy[i]), 16'd1);
        end

        // Streaming at full rate
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 4'(k);
            cycle();
        end
        in_valid = 1'b0;
        chk("stream_count", 0, o_cnt[0], 16'd20);
        cycle();

        // Randomised traffic with occasional clr and one mid-stream reset
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 40) == 0);
            if (n == 200) begin
                in_valid = 1'b1; out_ready = 1'b0; clr = 1'b0;
                cycle();
                cycle();
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                model_reset();
                cycle();
                rst_n = 1'b1;
            end
            cycle();
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
